// File: rtl/kahve_hakemi_pkg.sv
// kahve_pkg: shared state encoding and default durations for the coffee order controller.
package kahve_pkg;
    typedef enum logic [2:0] {BOS = 3'd0, DEMLE, SERVIS, BEKLE, BOSALT} durum_t;
    localparam int DEMLEME_VARS = 8;
    localparam int BOSALTMA_VARS = 4;
    localparam int ZAMAN_ASIMI_VARS = 16;
endpackage

// File: rtl/kahve_hakemi_rr_hakem.sv
// rr_hakem: combinational round-robin picker; searches from i_isaretci+1 (mod N).
module rr_hakem #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_istek,
    input  logic [W-1:0] i_isaretci,
    output logic         o_gecerli,
    output logic [W-1:0] o_kazanan
);
    logic [W-1:0] w_idx;
    // Walk from farthest to nearest so the nearest set bit is assigned last.
    always_comb begin
        o_gecerli = 1'b0;
        o_kazanan = '0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = W'((int'(i_isaretci) + k) % N);
            if (i_istek[w_idx]) begin
                o_gecerli = 1'b1;
                o_kazanan = w_idx;
            end
        end
    end
endmodule

// File: rtl/kahve_hakemi.sv
// kahve_hakemi: round-robin order controller sharing one servis dispenser among stations.
// Defining KAHVE_ZAMAN_ASIMI_EN adds a BEKLE timeout and the sticky hata output.
module kahve_hakemi
    import kahve_pkg::*;
#(
    parameter int ISTASYON_SAYISI = 4,
    parameter int DEMLEME_SURESI = DEMLEME_VARS,
    parameter int BOSALTMA_SURESI = BOSALTMA_VARS,
    parameter int ZAMAN_ASIMI = ZAMAN_ASIMI_VARS,
    localparam int W = $clog2(ISTASYON_SAYISI)
) (
    input  logic                       saat,
    input  logic                       reset,
    input  logic [ISTASYON_SAYISI-1:0] istek,
    input  logic [ISTASYON_SAYISI-1:0] filtre_istek,
    input  logic [ISTASYON_SAYISI-1:0] filtre_tipi_istek,
    output logic [ISTASYON_SAYISI-1:0] onay,
    output logic                       basla,
    output logic                       demlendi,
    output logic                       filtrele,
    output logic                       filtre_tipi,
    input  logic                       bitti,
    input  logic                       bosalt,
    output logic                       mesgul,
    output logic [W-1:0]               aktif_istasyon
`ifdef KAHVE_ZAMAN_ASIMI_EN
    ,
    output logic                       hata
`endif
);
    localparam int N = ISTASYON_SAYISI;
    localparam int MAKS = (DEMLEME_SURESI > BOSALTMA_SURESI) ? DEMLEME_SURESI : BOSALTMA_SURESI;
    localparam int SW = $clog2(MAKS + 1);
    localparam logic [N-1:0] BIR = N'(1);

    durum_t r_durum, w_sonraki;
    logic [SW-1:0] r_sayac;
    logic [W-1:0] r_idx, r_son, w_kazanan;
    logic [N-1:0] r_onay;
    logic r_filtre, r_tip, w_gecerli, w_zaman_doldu;

    rr_hakem #(.N(N)) u_hakem (
        .i_istek(istek),
        .i_isaretci(r_son),
        .o_gecerli(w_gecerli),
        .o_kazanan(w_kazanan)
    );

`ifdef KAHVE_ZAMAN_ASIMI_EN
    localparam int ZW = $clog2(ZAMAN_ASIMI + 1);
    logic [ZW-1:0] r_zaman;
    logic r_hata;
    assign w_zaman_doldu = (r_zaman == ZW'(ZAMAN_ASIMI - 1));
    assign hata = r_hata;
    always_ff @(posedge saat) begin
        if (reset) begin
            r_zaman <= '0;
            r_hata <= 1'b0;
        end else begin
            r_zaman <= (r_durum == BEKLE) ? r_zaman + 1'b1 : '0;
            if (r_durum == BEKLE && !bitti && w_zaman_doldu) r_hata <= 1'b1;
        end
    end
`else
    assign w_zaman_doldu = 1'b0;
`endif

    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            BOS:     w_sonraki = w_gecerli ? DEMLE : BOS;
            DEMLE:   w_sonraki = (r_sayac == '0) ? SERVIS : DEMLE;
            SERVIS:  w_sonraki = BEKLE;
            BEKLE:   w_sonraki = bitti ? (bosalt ? BOSALT : BOS) : (w_zaman_doldu ? BOS : BEKLE);
            BOSALT:  w_sonraki = (r_sayac == '0) ? BOS : BOSALT;
            default: w_sonraki = BOS;
        endcase
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            r_durum <= BOS;
            r_sayac <= '0;
            r_idx <= '0;
            r_son <= W'(N - 1);
            r_filtre <= 1'b0;
            r_tip <= 1'b0;
            r_onay <= '0;
        end else begin
            r_durum <= w_sonraki;
            r_onay <= '0;
            if (r_durum == BOS && w_gecerli) begin
                r_idx <= w_kazanan;
                r_filtre <= filtre_istek[w_kazanan];
                r_tip <= filtre_tipi_istek[w_kazanan];
                r_sayac <= SW'(DEMLEME_SURESI - 1);
            end
            if ((r_durum == DEMLE || r_durum == BOSALT) && r_sayac != '0) r_sayac <= r_sayac - 1'b1;
            if (r_durum == BEKLE && bitti) begin
                r_onay <= BIR << r_idx;
                r_son <= r_idx;
                if (bosalt) r_sayac <= SW'(BOSALTMA_SURESI - 1);
            end else if (r_durum == BEKLE && w_zaman_doldu) begin
                r_son <= r_idx;
            end
        end
    end

    assign onay = r_onay;
    assign basla = (r_durum == SERVIS);
    assign demlendi = (r_durum == SERVIS);
    assign filtrele = (r_durum == SERVIS) && r_filtre;
    assign filtre_tipi = (r_durum == SERVIS) && r_tip;
    assign mesgul = (r_durum != BOS);
    assign aktif_istasyon = r_idx;
endmodule
